// File: rtl/fifo_wr_burst.sv
// Write-side burst sequencer: takes a length command, then streams that many source words into the FIFO.
// A word accepted at edge N is written during cycle N+1; W_FULL holds the word and stops IN_READY.
module fifo_wr_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  BURST_REQ,
    input  logic [LEN_W-1:0]      BURST_LEN,
    output logic                  BURST_ACK,
    output logic                  BURST_ERR,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  W_FULL,
    output logic                  W_INC,
    output logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t                  state;
    logic                    hold_vld;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [LEN_W-1:0]        count;
    logic [LEN_W-1:0]        len;
    logic                    accept;
    logic                    len_ok;
    logic [LEN_W-1:0]        count_nxt;

    assign W_DATA    = hold_data;
    assign W_INC     = hold_vld && !W_FULL;
    // The hold stage may take a new word in the same cycle it drains the old one.
    assign IN_READY  = (state == XFER) && (count < len) && (!hold_vld || !W_FULL);
    assign accept    = IN_VALID && IN_READY;
    assign BUSY      = (state != IDLE);
    assign len_ok    = (BURST_LEN != '0) && (BURST_LEN <= MAX_LEN);
    assign count_nxt = count + LEN_W'(1);

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            state     <= IDLE;
            hold_vld  <= 1'b0;
            hold_data <= '0;
            count     <= '0;
            len       <= '0;
            BURST_ACK <= 1'b0;
            BURST_ERR <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            BURST_ACK <= 1'b0;
            BURST_ERR <= 1'b0;
            DONE      <= 1'b0;

            if (accept) begin
                hold_data <= IN_DATA;
                hold_vld  <= 1'b1;
            end else if (W_INC) begin
                hold_vld  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (BURST_REQ) begin
                        if (len_ok) begin
                            len       <= BURST_LEN;
                            count     <= '0;
                            BURST_ACK <= 1'b1;
                            state     <= XFER;
                        end else begin
                            BURST_ERR <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        count <= count_nxt;
                        if (count_nxt == len) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (W_INC) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_burst.sv
// Bench for fifo_wr_burst: source words queue into a scoreboard when accepted and are matched at each FIFO write.
module tb_fifo_wr_burst;

    localparam int DW    = 8;
    localparam int MB    = 16;
    localparam int LEN_W = $clog2(MB) + 1;

    logic             W_CLK = 1'b0;
    logic             W_RST = 1'b1;
    logic             BURST_REQ = 1'b0;
    logic [LEN_W-1:0] BURST_LEN = '0;
    logic             BURST_ACK, BURST_ERR;
    logic [DW-1:0]    IN_DATA = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic             W_FULL = 1'b0;
    logic             W_INC;
    logic [DW-1:0]    W_DATA;
    logic             BUSY, DONE;

    fifo_wr_burst #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST),
        .BURST_REQ(BURST_REQ), .BURST_LEN(BURST_LEN),
        .BURST_ACK(BURST_ACK), .BURST_ERR(BURST_ERR),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .W_FULL(W_FULL), .W_INC(W_INC), .W_DATA(W_DATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 W_CLK = ~W_CLK;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_wr = 0, n_ack = 0, n_err = 0, n_done = 0, wr_at_done = 0;
    bit  toggle = 1'b0;
    bit  tog_ph = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare each write against the oldest accepted word, then record new accepts.
    always @(negedge W_CLK) begin
        if (!W_RST) begin
            if (W_INC) begin
                check("inc_while_full", W_FULL, 0);
                if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
                else                   check("wr_data", W_DATA, exp_q.pop_front());
                n_wr++;
            end
            if (IN_VALID && IN_READY && src_q.size() > 0) exp_q.push_back(src_q.pop_front());
            if (BURST_ACK) n_ack++;
            if (BURST_ERR) n_err++;
            if (DONE) begin
                n_done++;
                wr_at_done = n_wr;
            end
        end
    end

    task automatic tick();
        @(posedge W_CLK);
        #1;
        tog_ph   = toggle ? !tog_ph : 1'b1;
        IN_VALID = (src_q.size() > 0) && tog_ph;
        if (src_q.size() > 0) IN_DATA = src_q[0];
        else                  IN_DATA = '0;
    endtask

    task automatic load_src(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + DW'(i));
        if (!IN_VALID && src_q.size() > 0) begin
            IN_VALID = tog_ph || !toggle;
            IN_DATA  = src_q[0];
        end
    endtask

    task automatic request(input int len);
        BURST_LEN = LEN_W'(len);
        BURST_REQ = 1'b1;
        tick();
        BURST_REQ = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int t  = 0;
        while (n_done == d0 && t < budget) begin
            tick();
            t++;
        end
        if (n_done == d0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        W_RST = 1'b1;
        tick();
        tick();
        check("rst_outs", {BURST_ACK, BURST_ERR, DONE, W_INC, IN_READY, BUSY}, 0);
        check("rst_wdata", W_DATA, 0);
        W_RST = 1'b0;
        tick();

        // LEN=4, continuous stream, back-to-back writes
        n_wr = 0;
        load_src(8'hA0, 4);
        request(4);
        check("t1_ack", BURST_ACK, 1);
        check("t1_busy", BUSY, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t1_inc", W_INC, 1);
            check("t1_data", W_DATA, 32'hA0 + i);
            tick();
        end
        check("t1_done", DONE, 1);
        check("t1_busy_low", BUSY, 0);
        check("t1_nwr", n_wr, 4);
        tick();
        check("t1_done_pulse", DONE, 0);

        // LEN=6 with a 3-cycle full stall on 0xB2
        n_wr = 0;
        load_src(8'hB0, 6);
        request(6);
        tick();
        tick();
        tick();
        check("t2_hold_b2", W_DATA, 32'hB2);
        W_FULL = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_stall_inc", W_INC, 0);
            check("t2_stall_data", W_DATA, 32'hB2);
            check("t2_stall_rdy", IN_READY, 0);
            tick();
        end
        W_FULL = 1'b0;
        wait_done(40);
        check("t2_nwr", n_wr, 6);
        check("t2_empty", exp_q.size(), 0);
        tick();

        // Illegal lengths
        n_wr = 0;
        n_ack = 0;
        n_err = 0;
        request(0);
        check("t3_err0", BURST_ERR, 1);
        check("t3_ack0", BURST_ACK, 0);
        check("t3_busy0", BUSY, 0);
        tick();
        check("t3_err_pulse", BURST_ERR, 0);
        request(17);
        check("t3_err17", BURST_ERR, 1);
        check("t3_busy17", BUSY, 0);
        tick();
        tick();
        check("t3_nerr", n_err, 2);
        check("t3_nack", n_ack, 0);
        check("t3_nwr", n_wr, 0);

        // Two LEN=16 bursts back to back, stray request during XFER
        n_wr = 0;
        n_ack = 0;
        n_err = 0;
        n_done = 0;
        load_src(8'hC0, 32);
        request(16);
        check("t4_ack1", BURST_ACK, 1);
        tick();
        BURST_LEN = LEN_W'(3);
        BURST_REQ = 1'b1;
        tick();
        tick();
        BURST_REQ = 1'b0;
        wait_done(60);
        check("t4_nwr1", n_wr, 16);
        request(16);
        check("t4_ack2", BURST_ACK, 1);
        wait_done(60);
        tick();
        check("t4_nwr", n_wr, 32);
        check("t4_nack", n_ack, 2);
        check("t4_nerr", n_err, 0);
        check("t4_ndone", n_done, 2);

        // Reset mid-burst, then a fresh LEN=2 burst
        n_wr = 0;
        load_src(8'h50, 8);
        request(8);
        for (int t = 0; t < 40 && n_wr < 3; t++) tick();
        check("t5_three_wr", n_wr, 3);
        W_RST = 1'b1;
        src_q.delete();
        tick();
        exp_q.delete();
        W_RST = 1'b0;
        check("t5_inc", W_INC, 0);
        check("t5_busy", BUSY, 0);
        check("t5_rdy", IN_READY, 0);
        tick();
        n_wr = 0;
        load_src(8'h60, 2);
        request(2);
        check("t5_ack", BURST_ACK, 1);
        wait_done(40);
        check("t5_nwr", n_wr, 2);

        // Toggling IN_VALID during a LEN=4 burst
        n_wr = 0;
        toggle = 1'b1;
        load_src(8'hE0, 4);
        request(4);
        wait_done(60);
        toggle = 1'b0;
        check("t6_nwr", n_wr, 4);
        check("t6_wr_at_done", wr_at_done, 4);
        tick();
        check("end_exp_empty", exp_q.size(), 0);
        check("end_src_empty", src_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
